// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch queue between instruction memory and IF/ID.
// Fetches sequential words into a DEPTH-entry FIFO of {instruction, pc+4} pairs
// and presents the oldest entry to ID with a valid/ready handshake. A redirect
// flushes the queue and restarts fetch at the new target.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   im_addr       word address to instruction memory (fetch_pc[11:2])
//   im_dout       instruction word read combinationally from im_addr
//   redirect      taken branch/jump: flush and restart fetch
//   redirect_pc   new fetch address, low two bits ignored
//   out_ready     ID accepts the head entry this cycle
//   out_valid     head entry present
//   out_ins       head instruction
//   out_pc_plus_4 head instruction address + 4
//   count         occupied entries, 0..DEPTH
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [9:0]               im_addr,
    input  logic [31:0]              im_dout,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_ins,
    output logic [31:0]              out_pc_plus_4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_fetch_pc_plus_4;
    logic [63:0]   w_head;
    logic          w_unused;

    // Handshake: redirect kills both directions; a same-cycle pop frees a slot
    assign w_pop             = out_valid & out_ready & ~redirect;
    assign w_push            = ~redirect & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_fetch_pc_plus_4 = r_fetch_pc + 32'd4;
    assign w_head            = r_mem[r_rd_ptr];
    assign w_unused          = ^redirect_pc[1:0];

    assign im_addr       = r_fetch_pc[11:2];
    assign out_valid     = (r_count != '0);
    assign out_ins       = w_head[63:32];
    assign out_pc_plus_4 = w_head[31:0];
    assign count         = r_count;

    // Control state: reset beats redirect, redirect beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PW'(1);
                r_fetch_pc <= w_fetch_pc_plus_4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Queue storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {im_dout, w_fetch_pc_plus_4};
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a scoreboard holds the expected
// {instruction, pc+4} stream for the current fetch target; a negedge monitor
// pops and compares on every accepted handshake.
module tb_if_prefetch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    im_addr;
    logic [31:0]   im_dout;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_ins;
    logic [31:0]   out_pc_plus_4;
    logic [CW-1:0] count;

    logic [31:0]   imem [1024];
    logic [63:0]   sb [$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_deliv  = 0;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .im_addr       (im_addr),
        .im_dout       (im_dout),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_ins       (out_ins),
        .out_pc_plus_4 (out_pc_plus_4),
        .count         (count)
    );

    always #5 clk = ~clk;

    assign im_dout = imem[im_addr];

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 + 32'(i);
    end

    function automatic logic [31:0] exp_ins(input logic [31:0] a);
        return 32'h1000_0000 + 32'(a[11:2]);
    endfunction

    // Replace expected stream with n sequential fetches starting at address a
    task automatic sb_fill(input logic [31:0] a, input int n);
        logic [31:0] pc;
        pc = a;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            sb.push_back({exp_ins(pc), pc + 32'd4});
            pc = pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted head must be the next expected entry
    always @(negedge clk) begin
        if (!rst && !redirect && out_valid && out_ready) begin
            logic [63:0] e;
            n_checks++;
            n_deliv++;
            if (sb.size() == 0) begin
                $display("FAIL deliver: got ins=%h pc4=%h, expected nothing", out_ins, out_pc_plus_4);
            end else begin
                e = sb.pop_front();
                if ({out_ins, out_pc_plus_4} !== e)
                    $display("FAIL deliver: got ins=%h pc4=%h, expected ins=%h pc4=%h",
                             out_ins, out_pc_plus_4, e[63:32], e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    // Hold reset for one edge, then release with the given out_ready
    task automatic do_reset(input logic ready);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick();
        rst = 1'b0; out_ready = ready;
        sb_fill(32'h0, 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", out_valid); else n_pass++;
        n_checks++;
        if (count !== '0) $display("FAIL reset_count: got %0d, expected 0", count); else n_pass++;
        n_checks++;
        if (im_addr !== 10'h000) $display("FAIL reset_im_addr: got %h, expected 000", im_addr); else n_pass++;
        rst = 1'b0; out_ready = 1'b1;
        sb_fill(32'h0, 40);
        tick();
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL first_valid: got %b, expected 1", out_valid); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (count !== CW'(1)) $display("FAIL stream_count[%0d]: got %0d, expected 1", k, count); else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int k = 1; k <= 10; k++) begin
            int m;
            tick();
            m = (k < 4) ? k : 4;
            n_checks++;
            if (count !== CW'(m)) $display("FAIL stall_count[%0d]: got %0d, expected %0d", k, count, m); else n_pass++;
            n_checks++;
            if (im_addr !== 10'(m)) $display("FAIL stall_im_addr[%0d]: got %h, expected %h", k, im_addr, 10'(m)); else n_pass++;
        end
    endtask

    task automatic test_full_swap();
        int d0;
        d0 = n_deliv;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== CW'(4)) $display("FAIL swap_count: got %0d, expected 4", count); else n_pass++;
        n_checks++;
        if (im_addr !== 10'h005) $display("FAIL swap_im_addr: got %h, expected 005", im_addr); else n_pass++;
        n_checks++;
        if (n_deliv !== d0 + 1) $display("FAIL swap_deliv: got %0d, expected %0d", n_deliv - d0, 1); else n_pass++;
        tick();
        n_checks++;
        if (im_addr !== 10'h005) $display("FAIL hold_im_addr: got %h, expected 005", im_addr); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (n_deliv !== d0 + 7) $display("FAIL drain_deliv: got %0d, expected %0d", n_deliv - d0, 7); else n_pass++;
        n_checks++;
        if (count !== CW'(4)) $display("FAIL drain_count: got %0d, expected 4", count); else n_pass++;
    endtask

    task automatic test_redirect();
        int d0;
        do_reset(1'b0);
        tick(); tick(); tick();
        n_checks++;
        if (count !== CW'(3)) $display("FAIL pre_redirect_count: got %0d, expected 3", count); else n_pass++;
        d0 = n_deliv;
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        sb_fill(32'h0000_0100, 20);
        tick();
        redirect = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL redir_valid: got %b, expected 0", out_valid); else n_pass++;
        n_checks++;
        if (count !== '0) $display("FAIL redir_count: got %0d, expected 0", count); else n_pass++;
        n_checks++;
        if (im_addr !== 10'h040) $display("FAIL redir_im_addr: got %h, expected 040", im_addr); else n_pass++;
        n_checks++;
        if (n_deliv !== d0) $display("FAIL redir_discard: got %0d deliveries, expected 0", n_deliv - d0); else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_ins !== 32'h1000_0040 || out_pc_plus_4 !== 32'h0000_0104)
            $display("FAIL redir_target: got v=%b ins=%h pc4=%h, expected v=1 ins=10000040 pc4=00000104",
                     out_valid, out_ins, out_pc_plus_4);
        else n_pass++;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_pc = 32'h0000_0300;
        sb_fill(32'h0000_0300, 20);
        tick();
        redirect = 1'b0;
        n_checks++;
        if (im_addr !== 10'h0C0) $display("FAIL b2b_im_addr: got %h, expected 0c0", im_addr); else n_pass++;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_rst_redirect();
        do_reset(1'b0);
        tick(); tick();
        n_checks++;
        if (count !== CW'(2)) $display("FAIL pre_rst_count: got %0d, expected 2", count); else n_pass++;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        n_checks++;
        if (count !== '0) $display("FAIL rstredir_count: got %0d, expected 0", count); else n_pass++;
        n_checks++;
        if (im_addr !== 10'h000) $display("FAIL rstredir_im_addr: got %h, expected 000", im_addr); else n_pass++;
        rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
        sb_fill(32'h0, 20);
        tick();
        n_checks++;
        if (out_ins !== 32'h1000_0000) $display("FAIL rstredir_head: got %h, expected 10000000", out_ins); else n_pass++;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc4 [3];
        logic [9:0]  exp_ia  [3];
        exp_pc4[0] = 32'hFFFF_FFFC; exp_pc4[1] = 32'h0000_0000; exp_pc4[2] = 32'h0000_0004;
        exp_ia[0]  = 10'h3FF;       exp_ia[1]  = 10'h000;       exp_ia[2]  = 10'h001;
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        sb_fill(32'hFFFF_FFF8, 20);
        tick();
        redirect = 1'b0;
        n_checks++;
        if (im_addr !== 10'h3FE) $display("FAIL wrap_im_addr0: got %h, expected 3fe", im_addr); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (out_pc_plus_4 !== exp_pc4[k] || im_addr !== exp_ia[k])
                $display("FAIL wrap[%0d]: got pc4=%h ia=%h, expected pc4=%h ia=%h",
                         k, out_pc_plus_4, im_addr, exp_pc4[k], exp_ia[k]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_full_swap();
        test_redirect();
        test_back_to_back();
        test_rst_redirect();
        test_wrap();
        out_ready = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction prefetch queue between instruction memory and the IF/ID pipeline register. It fetches sequential instructions from the 4 KB instruction memory into a small FIFO of {instruction, pc+4} pairs and presents the oldest entry to the ID stage with a valid/ready handshake. Taken branches and jumps from later stages redirect it, flushing all queued entries.

## Interface

Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- im_addr  output  10  word address to instruction memory, fetch_pc[11:2].
- im_dout  input  32  instruction word; combinational read of im_addr, valid same cycle.
- redirect  input  1  taken branch or jump; flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced to 0).
- out_ready  input  1  ID stage accepts the head entry this cycle.
- out_valid  output  1  head entry present.
- out_ins  output  32  head instruction.
- out_pc_plus_4  output  32  head instruction address + 4.
- count  output  clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation

- State: fetch_pc (32 b), FIFO storage DEPTH x 64 b, rd_ptr and wr_ptr (clog2(DEPTH) b, wrap modulo DEPTH), count.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & (count < DEPTH | pop): space exists now or is freed by this cycle's pop.
- On push: entry[wr_ptr] <= {im_dout, fetch_pc + 4}; wr_ptr++; fetch_pc <= fetch_pc + 4.
- On pop: rd_ptr++.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid = (count != 0); out_ins / out_pc_plus_4 = entry[rd_ptr] (combinational from storage). When out_valid = 0, out_ins and out_pc_plus_4 are don't-care; bench must not check them.
- Redirect (has priority over push and pop): rd_ptr <= 0, wr_ptr <= 0, count <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}. No entry is pushed or popped in a redirect cycle; the head presented that cycle is discarded even if out_ready = 1.
- Reset (priority over redirect): fetch_pc <= RESET_PC, pointers and count <= 0.
- fetch_pc increments across full 32 bits; wraps 32'hFFFF_FFFC -> 0. im_addr wraps within 4 KB naturally.
- Storage contents are not reset.

## Timing

- Reset values after rst edge: out_valid 0, count 0, im_addr = RESET_PC[11:2]; out_ins / out_pc_plus_4 don't-care.
- Fetch latency: instruction at fetch_pc is pushed on the edge where it is addressed; visible at out_* after that edge (1 cycle from address to out_valid).
- Throughput: one push and one pop per cycle; with out_ready held 1, queue steady at count 1, one instruction per cycle.
- Full (count = DEPTH): push only if same-cycle pop; fetch_pc holds otherwise.
- Empty (count = 0): pop impossible regardless of out_ready.
- Redirect at edge N: after N, out_valid 0, im_addr = redirect_pc[11:2]; after N+1, out_valid 1 with target instruction (2-cycle redirect penalty seen by ID).
- Back-to-back redirects: each restarts; only the last target fetches.
- rst and redirect same cycle: reset result, redirect_pc ignored.

## Test plan

- Reset then out_ready = 1, im holds word i = 32'h1000_0000 + i: out_valid rises one edge after reset release; out_ins sequence 1000_0000, 1000_0001, ... with out_pc_plus_4 = 4, 8, 12, one per cycle, count stays 1.
- out_ready = 0 for 10 cycles, DEPTH = 4: count 1,2,3,4 then holds 4; im_addr frozen at 4; raise out_ready: words 0..3 delivered in order, no loss or duplication.
- Full queue, out_ready = 1 for one cycle: simultaneous pop and push, count stays 4, fetch_pc advances by 4.
- Redirect with redirect_pc = 32'h0000_0103 while count = 3 and out_ready = 1: next cycle out_valid 0, count 0, im_addr = 10'h040; following cycle out_ins = word 0x40, out_pc_plus_4 = 32'h0000_0104; popped head not counted as delivered.
- rst and redirect asserted together at count = 2: im_addr = RESET_PC[11:2], count 0; redirect_pc never fetched.
- fetch_pc redirected to 32'hFFFF_FFF8, out_ready = 1: out_pc_plus_4 sequence FFFF_FFFC, 0000_0000, 0000_0004; im_addr 3FE, 3FF, 000.
